// File: rtl/norflash_pkg.sv
// Shared constants and types for the SPI NOR flash subsystem: APB/SPI widths and the
// state encoding of the two-requester APB arbiter.
package norflash_pkg;

  localparam int LINEWIDE   = 32;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_IO_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/norflash_rr_arb2.sv
// Two-input round-robin pick. Purely combinational; the caller owns the last_grant register.
module norflash_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/norflash_apb_arbiter.sv
// Shares the flash controller's APB slave port between two APB requesters, with
// round-robin grant, one setup+access per transfer and a watchdog on hung accesses.
module norflash_apb_arbiter
  import norflash_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              p_clk,
  input  logic              p_resetn,
  input  logic              s0_p_sel_x,
  input  logic              s0_p_enable,
  input  logic              s0_p_write,
  input  logic [ADDR_W-1:0] s0_p_addr,
  input  logic [DATA_W-1:0] s0_p_wdata,
  output logic [DATA_W-1:0] s0_p_rdata,
  output logic              s0_p_ready,
  output logic              s0_p_slverr,
  input  logic              s1_p_sel_x,
  input  logic              s1_p_enable,
  input  logic              s1_p_write,
  input  logic [ADDR_W-1:0] s1_p_addr,
  input  logic [DATA_W-1:0] s1_p_wdata,
  output logic [DATA_W-1:0] s1_p_rdata,
  output logic              s1_p_ready,
  output logic              s1_p_slverr,
  output logic              m_p_sel_x,
  output logic              m_p_enable,
  output logic              m_p_write,
  output logic [ADDR_W-1:0] m_p_addr,
  output logic [DATA_W-1:0] m_p_wdata,
  input  logic [DATA_W-1:0] m_p_rdata,
  input  logic              m_p_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  wdog_reg, wdog_next;
  logic              m_sel_reg, m_sel_next;
  logic              m_en_reg, m_en_next;
  logic              m_write_reg, m_write_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [1:0]        ready_next, err_next;
  logic [DATA_W-1:0] rdata_next [2];

  logic [1:0]        req;
  logic              grant_idx, grant_valid;

  // The enable phase is deliberately not qualified: a pending select alone is a request.
  logic              unused_enable;
  assign unused_enable = s0_p_enable ^ s1_p_enable;

  assign req = {s1_p_sel_x, s0_p_sel_x};

  norflash_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (grant_idx),
    .valid      (grant_valid)
  );

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      wdog_reg       <= '0;
      m_sel_reg      <= 1'b0;
      m_en_reg       <= 1'b0;
      m_write_reg    <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      wdog_reg       <= wdog_next;
      m_sel_reg      <= m_sel_next;
      m_en_reg       <= m_en_next;
      m_write_reg    <= m_write_next;
      m_addr_reg     <= m_addr_next;
      m_wdata_reg    <= m_wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    wdog_next       = wdog_reg;
    m_sel_next      = 1'b0;
    m_en_next       = 1'b0;
    m_write_next    = m_write_reg;
    m_addr_next     = m_addr_reg;
    m_wdata_next    = m_wdata_reg;
    ready_next      = 2'b00;
    err_next        = 2'b00;
    for (int i = 0; i < 2; i++) rdata_next[i] = '0;

    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          last_grant_next = grant_idx;
          m_write_next    = grant_idx ? s1_p_write : s0_p_write;
          m_addr_next     = grant_idx ? s1_p_addr  : s0_p_addr;
          m_wdata_next    = grant_idx ? s1_p_wdata : s0_p_wdata;
          m_sel_next      = 1'b1;
          state_next      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_sel_next = 1'b1;
        m_en_next  = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // last_grant_reg was updated at grant, so it names the current winner.
        if (m_p_ready) begin
          ready_next[last_grant_reg] = 1'b1;
          rdata_next[last_grant_reg] = m_write_reg ? '0 : m_p_rdata;
          state_next                 = ST_RESP;
        end else if (wdog_reg == CNT_W'(TIMEOUT - 1)) begin
          ready_next[last_grant_reg] = 1'b1;
          err_next[last_grant_reg]   = 1'b1;
          state_next                 = ST_RESP;
        end else begin
          wdog_next  = wdog_reg + CNT_W'(1);
          m_sel_next = 1'b1;
          m_en_next  = 1'b1;
        end
      end
      ST_RESP: begin
        wdog_next  = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m_p_sel_x  = m_sel_reg;
  assign m_p_enable = m_en_reg;
  assign m_p_write  = m_write_reg;
  assign m_p_addr   = m_addr_reg;
  assign m_p_wdata  = m_wdata_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_resp
      logic              ready_reg;
      logic              err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ready_reg <= ready_next[gi];
          err_reg   <= err_next[gi];
          rdata_reg <= rdata_next[gi];
        end
      end

      if (gi == 0) begin : gen_s0
        assign s0_p_ready  = ready_reg;
        assign s0_p_slverr = err_reg;
        assign s0_p_rdata  = rdata_reg;
      end else begin : gen_s1
        assign s1_p_ready  = ready_reg;
        assign s1_p_slverr = err_reg;
        assign s1_p_rdata  = rdata_reg;
      end
    end
  endgenerate

endmodule
